// File: rtl/rtype_cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle R-type sequencer: FSM states,
// instruction field constants and the ALU control codes understood by the ALU.
package rtype_cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OPC_RTYPE   = 6'h00;
  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/rtype_funct_decoder.sv
// Combinational opcode/funct decode into ALU control plus a legality flag.
// Unsupported encodings report legal=0 and fall back to the add code.
module rtype_funct_decoder
  import rtype_cpu_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    alu_op = ALU_ADD;
    legal  = 1'b0;
    if (opcode == OPC_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        default: legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/rtype_cpu_sequencer.sv
// Multi-cycle control FSM for the R-type datapath: owns PC and IR and steps
// each instruction through FETCH, DECODE, EXEC and WB, halting on request.
module rtype_cpu_sequencer
  import rtype_cpu_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS    = 64,
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic        clk_CPU,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] inst_addr,
  output logic        inst_rd_en,
  input  logic [31:0] inst_data,
  input  logic        inst_valid,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * (IMEM_WORDS - 1));
  localparam int unsigned TMO_W   = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       retired_q, retired_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              legal_q, legal_d;
  logic              fault_q, fault_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [3:0]        dec_alu_op;
  logic              dec_legal;
  logic              in_flight;
  logic              unused_shamt;

  rtype_funct_decoder u_decoder (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    alu_op_d  = alu_op_q;
    legal_d   = legal_q;
    fault_d   = fault_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = PC_RESET;
          tmo_d   = '0;
        end
      end
      ST_FETCH: begin
        // A word arriving on the last allowed cycle still wins over the timeout.
        if (inst_valid) begin
          ir_d    = inst_data;
          state_d = ST_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        if (ir_q[31:26] == HALT_OPCODE) begin
          state_d = ST_HALT;
        end else begin
          alu_op_d = dec_alu_op;
          legal_d  = dec_legal;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        retired_d = retired_q + 32'd1;
        pc_d      = (pc_q == PC_LAST) ? PC_RESET : pc_q + 32'd4;
        tmo_d     = '0;
        state_d   = stop ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (start && !stop) begin
          state_d = ST_FETCH;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_CPU) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      retired_q <= '0;
      alu_op_q  <= ALU_ADD;
      legal_q   <= 1'b0;
      fault_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      alu_op_q  <= alu_op_d;
      legal_q   <= legal_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
    end
  end

  // Register addresses are only presented while an instruction is in flight.
  assign in_flight = (state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB);

  assign inst_addr  = pc_q;
  assign inst_rd_en = (state_q == ST_FETCH);
  assign rs_addr    = in_flight ? ir_q[25:21] : 5'd0;
  assign rt_addr    = in_flight ? ir_q[20:16] : 5'd0;
  assign rd_addr    = in_flight ? ir_q[15:11] : 5'd0;
  assign alu_op     = alu_op_q;
  assign rf_we      = (state_q == ST_WB) && legal_q && (ir_q[15:11] != 5'd0);
  assign illegal    = (state_q == ST_WB) && !legal_q;
  assign busy       = in_flight || (state_q == ST_FETCH);
  assign halted     = (state_q == ST_HALT);
  assign fault      = fault_q;
  assign retired    = retired_q;

  assign unused_shamt = ^ir_q[10:6];

endmodule

// File: tb/tb_rtype_cpu_sequencer.sv
// Self-checking bench: a transaction-level reference of the sequencer is stepped
// alongside the DUT and compared every cycle; directed programs pin key values.
module tb_rtype_cpu_sequencer;

  localparam int          WORDS = 8;
  localparam int          TMO   = 8;
  localparam logic [31:0] PCR   = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic        clk_CPU;
  logic        rst, start, stop;
  logic [31:0] inst_addr, inst_data, retired;
  logic        inst_rd_en, inst_valid;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [3:0]  alu_op;
  logic        rf_we, busy, halted, fault, illegal;

  rtype_cpu_sequencer #(
    .PC_RESET      (PCR),
    .IMEM_WORDS    (WORDS),
    .FETCH_TIMEOUT (TMO)
  ) dut (
    .clk_CPU    (clk_CPU),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .inst_addr  (inst_addr),
    .inst_rd_en (inst_rd_en),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk_CPU = 1'b0;
  always #5 clk_CPU = ~clk_CPU;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level view of the sequencer.
  typedef enum {M_IDLE, M_FETCH, M_DEC, M_EXEC, M_WB, M_HALT} mph_e;

  mph_e        m_st;
  logic [31:0] m_pc, m_ir, m_ret;
  logic [3:0]  m_alu;
  logic        m_legal, m_fault;
  int          m_fetch_cycles;
  logic [31:0] mem [WORDS];

  logic [5:0] ref_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0] ref_op [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

  function automatic void ref_decode(input logic [31:0] ir, output logic [3:0] op, output logic lg);
    op = 4'b0010;
    lg = 1'b0;
    if (ir[31:26] == 6'd0)
      for (int i = 0; i < 6; i++)
        if (ir[5:0] == ref_fn[i]) begin
          op = ref_op[i];
          lg = 1'b1;
        end
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_st = M_IDLE; m_pc = PCR; m_ir = '0; m_ret = '0;
      m_alu = 4'b0010; m_legal = 1'b0; m_fault = 1'b0; m_fetch_cycles = 0;
    end else begin
      case (m_st)
        M_IDLE: if (start) begin m_st = M_FETCH; m_pc = PCR; m_fetch_cycles = 0; end
        M_FETCH: begin
          m_fetch_cycles++;
          if (inst_valid) begin m_ir = inst_data; m_st = M_DEC; end
          else if (m_fetch_cycles >= TMO) begin m_fault = 1'b1; m_st = M_HALT; end
        end
        M_DEC: begin
          if (m_ir[31:26] == 6'h3F) m_st = M_HALT;
          else begin ref_decode(m_ir, m_alu, m_legal); m_st = M_EXEC; end
        end
        M_EXEC: m_st = M_WB;
        M_WB: begin
          m_ret++;
          m_pc = PCR + 32'(4 * ((int'((m_pc - PCR) >> 2) + 1) % WORDS));
          m_fetch_cycles = 0;
          m_st = stop ? M_HALT : M_FETCH;
        end
        M_HALT: if (start && !stop) begin m_st = M_FETCH; m_fetch_cycles = 0; end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic compare();
    logic fl;
    fl = (m_st == M_DEC) || (m_st == M_EXEC) || (m_st == M_WB);
    check("inst_addr",  inst_addr,  m_pc);
    check("inst_rd_en", inst_rd_en, 32'(m_st == M_FETCH));
    check("rs_addr",    rs_addr,    fl ? 32'(m_ir[25:21]) : 32'd0);
    check("rt_addr",    rt_addr,    fl ? 32'(m_ir[20:16]) : 32'd0);
    check("rd_addr",    rd_addr,    fl ? 32'(m_ir[15:11]) : 32'd0);
    check("alu_op",     alu_op,     32'(m_alu));
    check("rf_we",      rf_we,      32'(m_st == M_WB && m_legal && m_ir[15:11] != 5'd0));
    check("illegal",    illegal,    32'(m_st == M_WB && !m_legal));
    check("busy",       busy,       32'(m_st inside {M_FETCH, M_DEC, M_EXEC, M_WB}));
    check("halted",     halted,     32'(m_st == M_HALT));
    check("fault",      fault,      32'(m_fault));
    check("retired",    retired,    m_ret);
  endtask

  task automatic drive_mem(input int pct);
    int idx;
    idx = int'((m_pc - PCR) >> 2) % WORDS;
    inst_valid = ($urandom_range(99) < pct);
    inst_data  = inst_valid ? mem[idx] : $urandom();
  endtask

  task automatic step(input int pct);
    drive_mem(pct);
    @(posedge clk_CPU);
    model_step();
    @(negedge clk_CPU);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    step(100);
    step(100);
    rst = 1'b0;
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_alu_op",    alu_op,    32'b0010);
    check("rst_busy",      busy,      32'd0);
    check("rst_retired",   retired,   32'd0);
    check("rst_fault",     fault,     32'd0);
  endtask

  task automatic advance_to(input mph_e ph, input int budget, input string name);
    int k = 0;
    while (m_st != ph && k < budget) begin
      step(100);
      k++;
    end
    if (m_st != ph) begin
      total++; bad++;
      $display("FAIL %s: phase not reached, got cycles=%0d want <%0d", name, k, budget);
    end
  endtask

  task automatic run_to_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      step(100);
      k++;
    end
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    r = $urandom_range(9);
    case (r)
      0, 1, 2, 3, 4, 5: return mk_r(5'($urandom()), 5'($urandom()), 5'($urandom()), ref_fn[r]);
      6: return mk_r(5'($urandom()), 5'($urandom()), 5'($urandom()), 6'h26);
      7: return {6'h23, 26'($urandom())};
      8: return HALT_WORD;
      default: return mk_r(5'd1, 5'd2, 5'($urandom()), 6'h20);
    endcase
  endfunction

  logic [3:0]  seen_ops [$];
  logic [31:0] wb_pcs [$];
  logic [3:0]  exp_ops [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  int          n_ill, n_we;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; inst_valid = 1'b0; inst_data = '0;

    // Single add, zero-wait memory.
    for (int i = 0; i < WORDS; i++) mem[i] = HALT_WORD;
    mem[0] = 32'h012A_4020;
    do_reset();
    start = 1'b1; step(100); start = 1'b0;
    step(100); step(100); step(100);
    check("add_rf_we",  rf_we,   32'd1);
    check("add_rd",     rd_addr, 32'd8);
    check("add_rs",     rs_addr, 32'd9);
    check("add_rt",     rt_addr, 32'd10);
    check("add_alu_op", alu_op,  32'b0010);
    step(100);
    check("add_retired", retired,   32'd1);
    check("add_pc",      inst_addr, 32'h4);
    run_to_halt(20);
    check("add_halted", halted, 32'd1);

    // Five ALU ops then halt sentinel.
    for (int i = 0; i < 5; i++) mem[i] = mk_r(5'd1, 5'd2, 5'd3, ref_fn[i + 1]);
    mem[5] = HALT_WORD;
    do_reset();
    start = 1'b1; step(100); start = 1'b0;
    for (int k = 0; k < 60 && !halted; k++) begin
      step(100);
      if (rf_we) seen_ops.push_back(alu_op);
    end
    check("seq_count", seen_ops.size(), 32'd5);
    for (int i = 0; i < 5 && i < seen_ops.size(); i++) check("seq_alu_op", seen_ops[i], exp_ops[i]);
    check("seq_halted",  halted,    32'd1);
    check("seq_retired", retired,   32'd5);
    check("seq_pc",      inst_addr, 32'h14);

    // Unsupported funct and rd=0.
    for (int i = 0; i < WORDS; i++) mem[i] = HALT_WORD;
    mem[0] = 32'h0129_4826;
    mem[1] = mk_r(5'd9, 5'd10, 5'd0, 6'h20);
    do_reset();
    n_ill = 0; n_we = 0;
    start = 1'b1; step(100); start = 1'b0;
    for (int k = 0; k < 40 && !halted; k++) begin
      step(100);
      if (illegal) n_ill++;
      if (rf_we) n_we++;
    end
    check("ill_pulses",  n_ill,     32'd1);
    check("ill_we",      n_we,      32'd0);
    check("ill_retired", retired,   32'd2);
    check("ill_pc",      inst_addr, 32'h8);

    // Fetch timeout, then resume at the same PC.
    mem[2] = mk_r(5'd1, 5'd2, 5'd4, 6'h24);
    mem[3] = HALT_WORD;
    start = 1'b1; step(0); start = 1'b0;
    repeat (7) step(0);
    check("tmo_still_fetch", inst_rd_en, 32'd1);
    check("tmo_no_fault",    fault,      32'd0);
    step(0);
    check("tmo_fault",  fault,     32'd1);
    check("tmo_halted", halted,    32'd1);
    check("tmo_pc",     inst_addr, 32'h8);
    start = 1'b1; step(100); start = 1'b0;
    check("resume_addr",  inst_addr,  32'h8);
    check("resume_rd_en", inst_rd_en, 32'd1);
    check("resume_fault", fault,      32'd1);
    run_to_halt(40);
    check("resume_retired", retired, 32'd3);
    start = 1'b1; stop = 1'b1;
    repeat (3) step(100);
    check("halt_start_stop", halted, 32'd1);
    start = 1'b0; stop = 1'b0;

    // PC wrap and stop timing.
    for (int i = 0; i < WORDS; i++) mem[i] = mk_r(5'(i), 5'(i + 1), 5'(i + 3), 6'h20);
    do_reset();
    start = 1'b1; step(100); start = 1'b0;
    for (int k = 0; k < 120 && wb_pcs.size() < 9; k++) begin
      step(100);
      if (rf_we) wb_pcs.push_back(inst_addr);
    end
    check("wrap_count", wb_pcs.size(), 32'd9);
    for (int i = 0; i < wb_pcs.size(); i++) check("wrap_pc", wb_pcs[i], 32'(4 * (i % WORDS)));
    advance_to(M_DEC, 20, "stop_dec_wait");
    stop = 1'b1; step(100); stop = 1'b0;
    step(100); step(100);
    check("stop_early_busy",   busy,    32'd1);
    check("stop_early_retired", retired, 32'd10);
    advance_to(M_EXEC, 20, "stop_exec_wait");
    stop = 1'b1; step(100); step(100); stop = 1'b0;
    check("stop_halted",  halted,    32'd1);
    check("stop_retired", retired,   32'd11);
    check("stop_pc",      inst_addr, 32'hC);

    // Reset in the middle of an instruction.
    start = 1'b1; step(100); start = 1'b0;
    advance_to(M_EXEC, 20, "rst_exec_wait");
    rst = 1'b1; step(100); rst = 1'b0;
    check("rst_exec_busy",    busy,      32'd0);
    check("rst_exec_halted",  halted,    32'd0);
    check("rst_exec_pc",      inst_addr, 32'h0);
    check("rst_exec_retired", retired,   32'd0);
    check("rst_exec_we",      rf_we,     32'd0);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 4; blk++) begin
      int pct;
      for (int i = 0; i < WORDS; i++) mem[i] = rand_word();
      pct = (blk == 0) ? 100 : (blk == 2) ? 20 : 70;
      for (int c = 0; c < 500; c++) begin
        rst   = ($urandom_range(299) == 0);
        start = ($urandom_range(3) == 0);
        stop  = ($urandom_range(9) == 0);
        step(pct);
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
